shared_adder_scheduler: RTL and testbench

//   Round-robin scheduler sharing one registered WIDTH-bit adder between NUM_REQ

---
 rtl/shared_adder_scheduler.sv | 131 +++++++++++++
 tb/tb_shared_adder_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/shared_adder_scheduler.sv
// Round-robin scheduler that time-shares one registered WIDTH-bit adder between
// NUM_REQ valid/ready requesters, stopping after a fixed budget of MAX_OPS grants.
module shared_adder_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int MAX_OPS = 10,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_carry,
    output logic                     rsp_has_x,
    output logic [31:0]              op_count,
    output logic                     done
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t            state, state_next;
    logic [ID_W-1:0]   rr_ptr;
    logic [31:0]       issue_count;
    logic [ID_W:0]     cand;
    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic              budget_left;
    logic              can_issue;
    logic              rsp_hs;
    logic [WIDTH-1:0]  a_sel, b_sel;
    logic [WIDTH:0]    add_result;
    logic              sum_has_x;

    assign budget_left = (issue_count < 32'(MAX_OPS));
    assign rsp_hs      = (state == BUSY) && rsp_ready;
    assign rsp_valid   = (state == BUSY);
    assign done        = (state == DONE);

    // Search upward from rr_ptr with wrap; the first valid index wins.
    // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ))
                cand = cand - (ID_W+1)'(NUM_REQ);
            if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    // A slot frees up either when nothing is held or when the held result retires now.
    assign can_issue = !rst && grant_found && budget_left &&
                       ((state == IDLE) || ((state == BUSY) && rsp_ready));

    always_comb begin
        req_ready = '0;
        if (can_issue)
            req_ready[grant_idx] = 1'b1;
    end

    assign a_sel      = req_a[grant_idx*WIDTH +: WIDTH];
    assign b_sel      = req_b[grant_idx*WIDTH +: WIDTH];
    assign add_result = {1'b0, a_sel} + {1'b0, b_sel};

`ifdef SYNTHESIS
    assign sum_has_x = 1'b0;
`else
    assign sum_has_x = (^add_result[WIDTH-1:0] === 1'bx);
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (can_issue)
                    state_next = BUSY;
                else if (!budget_left)
                    state_next = DONE;
            end
            BUSY: begin
                if (rsp_ready && !can_issue)
                    state_next = budget_left ? IDLE : DONE;
            end
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= (MAX_OPS == 0) ? DONE : IDLE;
            rr_ptr      <= '0;
            issue_count <= '0;
            op_count    <= '0;
            // NOTE: the result registers are reset too, so rsp_* read as zero after reset.
            rsp_id      <= '0;
            rsp_sum     <= '0;
            rsp_carry   <= 1'b0;
            rsp_has_x   <= 1'b0;
        end else begin
            state <= state_next;
            if (can_issue) begin
                rr_ptr      <= (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
                issue_count <= issue_count + 32'd1;
                rsp_id      <= grant_idx;
                rsp_sum     <= add_result[WIDTH-1:0];
                rsp_carry   <= add_result[WIDTH];
                rsp_has_x   <= sum_has_x;
            end
            if (rsp_hs)
                op_count <= op_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_shared_adder_scheduler.sv
// Directed bench for shared_adder_scheduler: a vector table for grants and sums,
// plus hand-written sequences for X propagation, reset mid-op and backpressure/budget.
module tb_shared_adder_scheduler;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance, default budget of 10.
    logic        rst;
    logic [3:0]  req_valid;
    logic [63:0] req_a, req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid, rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_sum;
    logic        rsp_carry, rsp_has_x;
    logic [31:0] op_count;
    logic        done;

    // Second instance with a budget of 3.
    logic        b_rst;
    logic [3:0]  b_req_valid;
    logic [63:0] b_req_a, b_req_b;
    logic [3:0]  b_req_ready;
    logic        b_rsp_valid, b_rsp_ready;
    logic [1:0]  b_rsp_id;
    logic [15:0] b_rsp_sum;
    logic        b_rsp_carry, b_rsp_has_x;
    logic [31:0] b_op_count;
    logic        b_done;

    shared_adder_scheduler #(.NUM_REQ(4), .WIDTH(16), .MAX_OPS(10)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_carry(rsp_carry),
        .rsp_has_x(rsp_has_x), .op_count(op_count), .done(done)
    );

    shared_adder_scheduler #(.NUM_REQ(4), .WIDTH(16), .MAX_OPS(3)) dut_b (
        .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_a(b_req_a), .req_b(b_req_b),
        .req_ready(b_req_ready), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_id(b_rsp_id), .rsp_sum(b_rsp_sum), .rsp_carry(b_rsp_carry),
        .rsp_has_x(b_rsp_has_x), .op_count(b_op_count), .done(b_done)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  exp_ready;
        logic        exp_valid;
        logic [1:0]  exp_id;
        logic [15:0] exp_sum;
        logic        exp_carry;
    } vec_t;

    vec_t vecs[8];

    // A 4-state simulator keeps X; a 2-state one turns it into a known value.
    logic xprobe;
    bit   is4state;

    localparam logic [63:0] RR_A = {16'h0300, 16'h0200, 16'h0100, 16'h2000};
    localparam logic [63:0] RR_B = {16'h0003, 16'h0002, 16'h0001, 16'hF000};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        xprobe   = 1'bx;
        is4state = (xprobe === 1'bx);

        // Round-robin from reset: 0,1,2,3 then wrap to 0.
        vecs[0] = '{4'b1111, RR_A, RR_B, 4'b0001, 1'b1, 2'd0, 16'h1000, 1'b1};
        vecs[1] = '{4'b1111, RR_A, RR_B, 4'b0010, 1'b1, 2'd1, 16'h0101, 1'b0};
        vecs[2] = '{4'b1111, RR_A, RR_B, 4'b0100, 1'b1, 2'd2, 16'h0202, 1'b0};
        vecs[3] = '{4'b1111, RR_A, RR_B, 4'b1000, 1'b1, 2'd3, 16'h0303, 1'b0};
        vecs[4] = '{4'b1111, RR_A, RR_B, 4'b0001, 1'b1, 2'd0, 16'h1000, 1'b1};
        // Single op on index 0 while rr_ptr=1: the search wraps to 0.
        vecs[5] = '{4'b0001, 64'h0000_0000_0000_4200, 64'h0000_0000_0000_0200,
                    4'b0001, 1'b1, 2'd0, 16'h4400, 1'b0};
        // Overflow on index 2.
        vecs[6] = '{4'b0100, 64'h0000_FFFF_0000_0000, 64'h0000_0001_0000_0000,
                    4'b0100, 1'b1, 2'd2, 16'h0000, 1'b1};
        // No request: nothing granted, previous result retires.
        vecs[7] = '{4'b0000, 64'h0, 64'h0, 4'b0000, 1'b0, 2'd0, 16'h0000, 1'b0};

        rst = 1'b1; req_valid = 4'b1111; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        b_rst = 1'b1; b_req_valid = '0; b_req_a = '0; b_req_b = '0; b_rsp_ready = 1'b0;
        tick();
        tick();

        check("reset req_ready", 32'(req_ready), 32'h0);
        check("reset rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset rsp_id",    32'(rsp_id),    32'h0);
        check("reset rsp_sum",   32'(rsp_sum),   32'h0);
        check("reset rsp_carry", 32'(rsp_carry), 32'h0);
        check("reset rsp_has_x", 32'(rsp_has_x), 32'h0);
        check("reset op_count",  op_count,       32'h0);
        check("reset done",      32'(done),      32'h0);

        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            req_valid = vecs[i].valid;
            req_a     = vecs[i].a;
            req_b     = vecs[i].b;
            #1;
            check($sformatf("vec%0d req_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
            tick();
            check($sformatf("vec%0d rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d rsp_id", i),    32'(rsp_id),    32'(vecs[i].exp_id));
                check($sformatf("vec%0d rsp_sum", i),   32'(rsp_sum),   32'(vecs[i].exp_sum));
                check($sformatf("vec%0d rsp_carry", i), 32'(rsp_carry), 32'(vecs[i].exp_carry));
                check($sformatf("vec%0d rsp_has_x", i), 32'(rsp_has_x), 32'h0);
            end
        end
        check("op_count after table", op_count, 32'd7);
        check("done after table", 32'(done), 32'h0);

        // X propagation on index 1 (rr_ptr=3, search wraps 3,0,1).
        req_valid = 4'b0010;
        req_a     = '0;
        req_b     = '0;
        req_a[31:16] = 16'b0100001000000000;
        req_b[31:16] = 16'b0000x1000000000;
        #1;
        check("xprop req_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b0000;
        check("xprop rsp_valid", 32'(rsp_valid), 32'h1);
        check("xprop rsp_id", 32'(rsp_id), 32'h1);
        check("xprop low sum bits", 32'(rsp_sum[9:0]), 32'h0);
        check("xprop rsp_has_x", 32'(rsp_has_x), 32'(is4state));
        tick();
        check("op_count after xprop", op_count, 32'd8);

        // Reset mid-operation: hold a result, then reset.
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        req_a     = 64'h1;
        req_b     = 64'h2;
        tick();
        req_valid = 4'b0000;
        check("midop rsp_valid", 32'(rsp_valid), 32'h1);
        check("midop rsp_sum", 32'(rsp_sum), 32'h3);
        tick();
        check("midop held rsp_sum", 32'(rsp_sum), 32'h3);
        rst = 1'b1;
        req_valid = 4'b1111;
        #1;
        check("midop req_ready in reset", 32'(req_ready), 32'h0);
        tick();
        check("midop rsp_valid after rst", 32'(rsp_valid), 32'h0);
        check("midop op_count after rst", op_count, 32'h0);
        check("midop done after rst", 32'(done), 32'h0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check("midop first grant", 32'(req_ready), 32'h1);
        tick();
        check("midop first rsp_id", 32'(rsp_id), 32'h0);

        // Backpressure and budget exhaustion on the MAX_OPS=3 instance.
        b_rst = 1'b0;
        b_req_valid = 4'b1111;
        b_req_a = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        b_req_b = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
        #1;
        check("budget first grant", 32'(b_req_ready), 32'h1);
        tick();
        check("budget rsp_valid", 32'(b_rsp_valid), 32'h1);
        check("budget rsp_sum0", 32'(b_rsp_sum), 32'h0011);
        check("budget stall req_ready", 32'(b_req_ready), 32'h0);
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("stall%0d rsp_valid", c), 32'(b_rsp_valid), 32'h1);
            check($sformatf("stall%0d rsp_id", c), 32'(b_rsp_id), 32'h0);
            check($sformatf("stall%0d rsp_sum", c), 32'(b_rsp_sum), 32'h0011);
            check($sformatf("stall%0d req_ready", c), 32'(b_req_ready), 32'h0);
        end
        check("budget op_count stalled", b_op_count, 32'h0);
        b_rsp_ready = 1'b1;
        #1;
        check("budget second grant", 32'(b_req_ready), 32'h2);
        tick();
        check("budget rsp_id1", 32'(b_rsp_id), 32'h1);
        check("budget rsp_sum1", 32'(b_rsp_sum), 32'h0022);
        check("budget third grant", 32'(b_req_ready), 32'h4);
        tick();
        check("budget rsp_id2", 32'(b_rsp_id), 32'h2);
        check("budget rsp_sum2", 32'(b_rsp_sum), 32'h0033);
        check("budget no fourth grant", 32'(b_req_ready), 32'h0);
        check("budget done before retire", 32'(b_done), 32'h0);
        tick();
        check("budget rsp_valid end", 32'(b_rsp_valid), 32'h0);
        check("budget op_count", b_op_count, 32'd3);
        check("budget done", 32'(b_done), 32'h1);
        check("budget req_ready end", 32'(b_req_ready), 32'h0);
        tick();
        tick();
        check("budget done sticky", 32'(b_done), 32'h1);
        check("budget req_ready sticky", 32'(b_req_ready), 32'h0);
        check("budget op_count sticky", b_op_count, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
